// File: rtl/dcache_miss_ctrl_if.sv
// Memory-side request/response bus of the data-cache miss controller.
interface dcache_miss_ctrl_if;
    logic        req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, wr, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, wr, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss controller: dirty-victim write-back followed by a
// word-by-word line refill, stalling the CPU until the line is valid.
module dcache_miss_ctrl #(
    parameter int  WAY_NUM        = 4,
    parameter int  WORDS_PER_LINE = 8,
    parameter int  INDEX_WIDTH    = 7,
    parameter int  TAG_WIDTH      = 20,
    localparam int WAY_W  = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1,
    localparam int WORD_W = $clog2(WORDS_PER_LINE)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cpu_req,
    input  logic [31:0]            cpu_addr,
    input  logic                   hit,
    input  logic [31:0]            victim_way,
    input  logic                   victim_valid,
    input  logic                   victim_dirty,
    input  logic [TAG_WIDTH-1:0]   victim_tag,
    input  logic [31:0]            victim_rdata,
    output logic                   stall,
    output logic                   busy,
    output logic [WORD_W-1:0]      wb_word_idx,
    dcache_miss_ctrl_if.master     mem,
    output logic                   refill_we,
    output logic [WAY_W-1:0]       refill_way,
    output logic [INDEX_WIDTH-1:0] refill_index,
    output logic [WORD_W-1:0]      refill_word,
    output logic [31:0]            refill_data,
    output logic                   tag_we
);
    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        RF_REQ,
        RF_WAIT,
        DONE
    } state_t;

    localparam int IDX_LO = WORD_W + 2;
    localparam int TAG_LO = IDX_LO + INDEX_WIDTH;
    localparam logic [WORD_W-1:0] LAST = WORD_W'(WORDS_PER_LINE - 1);

    state_t               state;
    logic [WORD_W-1:0]    cnt;
    logic [TAG_WIDTH-1:0] miss_tag;
    logic [TAG_WIDTH-1:0] wb_tag;
    logic                 miss;
    logic                 unused_addr;

    assign unused_addr = ^cpu_addr[IDX_LO-1:0];

    assign miss        = cpu_req & ~hit & ~reset;
    assign busy        = (state != IDLE);
    assign stall       = busy | miss;
    assign wb_word_idx = cnt;

    always_comb begin
        mem.req   = 1'b0;
        mem.wr    = 1'b0;
        mem.addr  = '0;
        mem.wdata = '0;
        unique case (state)
            WB_REQ: begin
                mem.req   = 1'b1;
                mem.wr    = 1'b1;
                mem.addr  = {wb_tag, refill_index, cnt, 2'b00};
                mem.wdata = victim_rdata;
            end
            RF_REQ: begin
                mem.req  = 1'b1;
                mem.addr = {miss_tag, refill_index, cnt, 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            miss_tag     <= '0;
            wb_tag       <= '0;
            refill_way   <= '0;
            refill_index <= '0;
            refill_word  <= '0;
            refill_data  <= '0;
            refill_we    <= 1'b0;
            tag_we       <= 1'b0;
        end else begin
            refill_we <= 1'b0;
            tag_we    <= 1'b0;
            unique case (state)
                IDLE: if (miss) begin
                    miss_tag     <= cpu_addr[31:TAG_LO];
                    refill_index <= cpu_addr[TAG_LO-1:IDX_LO];
                    refill_way   <= WAY_W'(victim_way % 32'(WAY_NUM));
                    wb_tag       <= victim_tag;
                    cnt          <= '0;
                    state        <= (victim_valid && victim_dirty) ? WB_REQ : RF_REQ;
                end
                WB_REQ: if (mem.gnt) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= RF_REQ;
                end
                RF_REQ: if (mem.gnt) state <= RF_WAIT;
                RF_WAIT: if (mem.rvalid) begin
                    // Data-array write lands one cycle after rvalid;
                    // the last word also commits the tag in that cycle.
                    refill_we   <= 1'b1;
                    refill_word <= cnt;
                    refill_data <= mem.rdata;
                    cnt         <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        tag_we <= 1'b1;
                        state  <= DONE;
                    end else begin
                        state <= RF_REQ;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Randomized self-checking bench for dcache_miss_ctrl with a
// transaction-level model of write-back, refill and stall length.
`timescale 1ns/1ps
module tb_dcache_miss_ctrl;
    localparam int W    = 8;
    localparam int WAYS = 4;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_op_t;

    typedef struct packed {
        logic [1:0]  way;
        logic [6:0]  index;
        logic [2:0]  word;
        logic [31:0] data;
    } refill_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        hit;
    logic [31:0] victim_way;
    logic        victim_valid;
    logic        victim_dirty;
    logic [19:0] victim_tag;
    logic [31:0] victim_rdata;
    logic        stall;
    logic        busy;
    logic [2:0]  wb_word_idx;
    logic        refill_we;
    logic [1:0]  refill_way;
    logic [6:0]  refill_index;
    logic [2:0]  refill_word;
    logic [31:0] refill_data;
    logic        tag_we;

    logic [31:0] vline [W];
    logic [31:0] rline [W];
    int n_tests = 0;
    int n_fail  = 0;

    dcache_miss_ctrl_if mem ();

    dcache_miss_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_addr     (cpu_addr),
        .hit          (hit),
        .victim_way   (victim_way),
        .victim_valid (victim_valid),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag),
        .victim_rdata (victim_rdata),
        .stall        (stall),
        .busy         (busy),
        .wb_word_idx  (wb_word_idx),
        .mem          (mem),
        .refill_we    (refill_we),
        .refill_way   (refill_way),
        .refill_index (refill_index),
        .refill_word  (refill_word),
        .refill_data  (refill_data),
        .tag_we       (tag_we)
    );

    always #5 clk = ~clk;

    // Victim line array read port, indexed by the write-back word pointer.
    assign victim_rdata = vline[wb_word_idx];

    task automatic set_lines(input bit rnd);
        for (int w = 0; w < W; w++) begin
            vline[w] = rnd ? $urandom : 32'hD000_0000 + 32'(w);
            rline[w] = rnd ? $urandom : 32'(w);
        end
    endtask

    task automatic do_miss(
        input logic [31:0] addr,
        input logic [31:0] way,
        input bit          vv,
        input bit          vd,
        input logic [19:0] vtag,
        input int          bp_word,
        input int          bp_cycles,
        input int          max_rv,
        input int          abort_word
    );
        mem_op_t     exp_mem [$];
        refill_t     exp_rf [$];
        mem_op_t     op;
        refill_t     rfe;
        int          d [W];
        int          exp_stall, stall_cnt, tag_seen, rf_seen;
        int          bp_left, rv_cnt, rd_word, cyc;
        bit          rd_pending, dirty_wb, abort_next, done;
        logic [6:0]  idx;
        logic [19:0] tag;
        logic [1:0]  ew;
        logic [2:0]  wv;

        idx      = addr[11:5];
        tag      = addr[31:12];
        ew       = 2'(way % WAYS);
        dirty_wb = vv && vd;
        exp_stall = 2 + 2 * W + ((bp_word >= 0) ? bp_cycles : 0);
        if (dirty_wb) exp_stall += W + ((bp_word >= 0) ? bp_cycles : 0);
        for (int w = 0; w < W; w++) begin
            wv   = 3'(w);
            d[w] = (max_rv > 0) ? int'($urandom_range(max_rv)) : 0;
            exp_stall += d[w];
            if (dirty_wb) exp_mem.push_back({1'b1, vtag, idx, wv, 2'b00, vline[w]});
        end
        for (int w = 0; w < W; w++) begin
            wv = 3'(w);
            exp_mem.push_back({1'b0, tag, idx, wv, 2'b00, 32'h0});
            exp_rf.push_back({ew, idx, wv, rline[w]});
        end

        @(negedge clk);
        cpu_req      = 1'b1;
        hit          = 1'b0;
        cpu_addr     = addr;
        victim_way   = way;
        victim_valid = vv;
        victim_dirty = vd;
        victim_tag   = vtag;
        mem.gnt      = 1'b0;
        mem.rvalid   = 1'b0;
        #1;
        n_tests++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL miss_stall: got %b expected 1", stall);
        end
        n_tests++;
        if (busy !== 1'b0 || mem.req !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_idle: busy=%b req=%b expected 0 0", busy, mem.req);
        end

        stall_cnt  = 1;
        tag_seen   = 0;
        rf_seen    = 0;
        bp_left    = bp_cycles;
        rv_cnt     = 0;
        rd_word    = 0;
        rd_pending = 0;
        abort_next = 0;
        done       = 0;
        cyc        = 0;
        while (!done && cyc < 600) begin
            cyc++;
            @(negedge clk);
            cpu_req      = 1'b0;
            hit          = 1'($urandom_range(1));
            cpu_addr     = $urandom;
            victim_way   = $urandom;
            victim_tag   = 20'($urandom);
            victim_valid = 1'($urandom_range(1));
            victim_dirty = 1'($urandom_range(1));
            mem.gnt      = 1'b0;
            mem.rvalid   = 1'b0;
            mem.rdata    = $urandom;
            if (abort_next) begin
                reset = 1'b1;
                @(negedge clk);
                n_tests++;
                if (stall !== 1'b0 || busy !== 1'b0 || mem.req !== 1'b0 ||
                    tag_we !== 1'b0 || refill_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_state: stall=%b busy=%b req=%b tag_we=%b refill_we=%b expected all 0",
                             stall, busy, mem.req, tag_we, refill_we);
                end
                reset = 1'b0;
                done  = 1;
            end else begin
                if (rd_pending) begin
                    if (rv_cnt == 0) begin
                        mem.rvalid = 1'b1;
                        mem.rdata  = rline[rd_word];
                        rd_pending = 0;
                    end else begin
                        rv_cnt--;
                    end
                end else if ($urandom_range(3) == 0) begin
                    mem.rvalid = 1'b1;
                end
                if (mem.req === 1'b1) begin
                    op = (exp_mem.size() > 0) ? exp_mem[0] : '0;
                    n_tests++;
                    if (exp_mem.size() == 0 || mem.wr !== op.wr || mem.addr !== op.addr ||
                        (op.wr && mem.wdata !== op.data)) begin
                        n_fail++;
                        $display("FAIL mem_req: got wr=%b addr=%h wdata=%h expected wr=%b addr=%h wdata=%h",
                                 mem.wr, mem.addr, mem.wdata, op.wr, op.addr, op.data);
                    end
                    if (bp_word >= 0 && int'(op.addr[4:2]) == bp_word && bp_left > 0) begin
                        bp_left--;
                    end else begin
                        mem.gnt = 1'b1;
                        if (exp_mem.size() > 0) void'(exp_mem.pop_front());
                        if (int'(op.addr[4:2]) == bp_word) bp_left = bp_cycles;
                        if (!op.wr) begin
                            rd_pending = 1;
                            rd_word    = int'(op.addr[4:2]);
                            rv_cnt     = d[rd_word];
                            if (abort_word >= 0 && rd_word == abort_word + 1) abort_next = 1;
                        end
                    end
                end else if ($urandom_range(3) == 0) begin
                    mem.gnt = 1'b1;
                end
                #1;
                if (stall === 1'b1) begin
                    stall_cnt++;
                    n_tests++;
                    if (busy !== 1'b1) begin
                        n_fail++;
                        $display("FAIL busy: got %b expected 1", busy);
                    end
                end else begin
                    done = 1;
                end
                if (refill_we === 1'b1) begin
                    rfe = (exp_rf.size() > 0) ? exp_rf[0] : 'x;
                    n_tests++;
                    if (exp_rf.size() == 0 ||
                        {refill_way, refill_index, refill_word, refill_data} !== rfe) begin
                        n_fail++;
                        $display("FAIL refill: got way=%0d idx=%h word=%0d data=%h expected way=%0d idx=%h word=%0d data=%h",
                                 refill_way, refill_index, refill_word, refill_data,
                                 rfe.way, rfe.index, rfe.word, rfe.data);
                    end
                    if (exp_rf.size() > 0) void'(exp_rf.pop_front());
                    rf_seen++;
                end
                if (tag_we === 1'b1) begin
                    tag_seen++;
                    n_tests++;
                    if (refill_we !== 1'b1 || refill_word !== 3'(W - 1) ||
                        refill_way !== ew || refill_index !== idx) begin
                        n_fail++;
                        $display("FAIL tag_we: got we=%b word=%0d way=%0d idx=%h expected 1 %0d %0d %h",
                                 refill_we, refill_word, refill_way, refill_index, W - 1, ew, idx);
                    end
                end
            end
        end
        mem.gnt    = 1'b0;
        mem.rvalid = 1'b0;

        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL timeout: got no stall release in %0d cycles, expected %0d", cyc, exp_stall);
        end
        if (abort_word >= 0) begin
            n_tests++;
            if (rf_seen != abort_word + 1 || tag_seen != 0) begin
                n_fail++;
                $display("FAIL abort_progress: got refills=%0d tag_we=%0d expected %0d 0",
                         rf_seen, tag_seen, abort_word + 1);
            end
        end else begin
            n_tests++;
            if (stall_cnt != exp_stall) begin
                n_fail++;
                $display("FAIL latency: got %0d stall cycles expected %0d", stall_cnt, exp_stall);
            end
            n_tests++;
            if (exp_mem.size() != 0 || exp_rf.size() != 0 || tag_seen != 1) begin
                n_fail++;
                $display("FAIL completion: got left_mem=%0d left_rf=%0d tag_we=%0d expected 0 0 1",
                         exp_mem.size(), exp_rf.size(), tag_seen);
            end
            n_tests++;
            if (mem.req !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_after: req=%b busy=%b expected 0 0", mem.req, busy);
            end
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        cpu_req = 1'b1;
        hit     = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (stall !== 1'b0 || busy !== 1'b0 || mem.req !== 1'b0 || mem.wr !== 1'b0 ||
            mem.addr !== 32'h0 || refill_we !== 1'b0 || tag_we !== 1'b0 ||
            refill_way !== 2'd0 || refill_index !== 7'd0 || refill_word !== 3'd0 ||
            refill_data !== 32'h0 || wb_word_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: stall=%b busy=%b req=%b addr=%h we=%b tag_we=%b way=%0d expected all 0",
                     stall, busy, mem.req, mem.addr, refill_we, tag_we, refill_way);
        end
        cpu_req = 1'b0;
        reset   = 1'b0;
    endtask

    task automatic test_hit();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cpu_req    = 1'b1;
            hit        = 1'b1;
            cpu_addr   = $urandom;
            mem.gnt    = 1'($urandom_range(1));
            mem.rvalid = 1'($urandom_range(1));
            #1;
            n_tests++;
            if (stall !== 1'b0 || busy !== 1'b0 || mem.req !== 1'b0 || refill_we !== 1'b0) begin
                n_fail++;
                $display("FAIL hit: stall=%b busy=%b req=%b refill_we=%b expected 0 0 0 0",
                         stall, busy, mem.req, refill_we);
            end
        end
        @(negedge clk);
        cpu_req    = 1'b0;
        hit        = 1'b0;
        mem.gnt    = 1'b0;
        mem.rvalid = 1'b0;
    endtask

    task automatic test_clean_miss();
        set_lines(0);
        do_miss(32'h0000_1040, 32'd2, 1'b1, 1'b0, 20'h12345, -1, 0, 0, -1);
    endtask

    task automatic test_dirty_miss();
        set_lines(0);
        do_miss(32'h0000_1040, 32'd3, 1'b1, 1'b1, 20'hABCDE, -1, 0, 0, -1);
    endtask

    task automatic test_backpressure();
        set_lines(0);
        do_miss(32'h0000_1040, 32'd0, 1'b1, 1'b0, 20'h00000, 3, 3, 0, -1);
        set_lines(1);
        do_miss(32'h7654_3210, 32'd1, 1'b1, 1'b1, 20'h5A5A5, 3, 3, 1, -1);
    endtask

    task automatic test_way_mod();
        set_lines(0);
        do_miss(32'h0000_2080, 32'd5, 1'b0, 1'b1, 20'hFFFFF, -1, 0, 0, -1);
    endtask

    task automatic test_reset_mid();
        set_lines(1);
        do_miss(32'h0000_1040, 32'd2, 1'b1, 1'b0, 20'h00001, -1, 0, 0, 4);
        set_lines(1);
        do_miss(32'h0003_F0E0, 32'd3, 1'b1, 1'b0, 20'h00002, -1, 0, 0, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            set_lines(1);
            do_miss($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)),
                    20'($urandom), int'($urandom_range(8)) - 1, int'($urandom_range(4)),
                    int'($urandom_range(3)), -1);
        end
    endtask

    initial begin
        reset        = 1'b1;
        cpu_req      = 1'b0;
        cpu_addr     = 32'h0;
        hit          = 1'b0;
        victim_way   = 32'h0;
        victim_valid = 1'b0;
        victim_dirty = 1'b0;
        victim_tag   = 20'h0;
        mem.gnt      = 1'b0;
        mem.rvalid   = 1'b0;
        mem.rdata    = 32'h0;
        set_lines(0);
        test_reset();
        test_hit();
        test_clean_miss();
        test_dirty_miss();
        test_backpressure();
        test_way_mod();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache_miss_ctrl.md
Name: dcache_miss_ctrl

Overview:
- Miss-handling controller for the data cache; sits directly downstream of the round-robin replacement selector and consumes its victim index.
- On a lookup miss it latches the victim way, writes the dirty victim line back word by word, then refills the line from memory.
- Drives data/tag array write strobes and holds the CPU pipeline stalled until the line is valid.

Parameters:
WAY_NUM, 4, number of ways; victim index is taken modulo WAY_NUM.
WORDS_PER_LINE, 8, 32-bit words per line; power of two, at least 2.
INDEX_WIDTH, 7, set index bits.
TAG_WIDTH, 20, tag bits; TAG_WIDTH + INDEX_WIDTH + log2(WORDS_PER_LINE) + 2 = 32.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cpu_req  in  1  lookup valid this cycle
cpu_addr  in  32  lookup address
hit  in  1  lookup hit from the tag compare
victim_way  in  32  way chosen by the replacement selector
victim_valid  in  1  victim line valid
victim_dirty  in  1  victim line dirty
victim_tag  in  TAG_WIDTH  victim line tag
victim_rdata  in  32  victim data word addressed by wb_word_idx, available combinationally
stall  out  1  CPU hold; asserted while a miss is in service
busy  out  1  FSM not in IDLE; feeds the replacement selector
wb_word_idx  out  log2(WORDS_PER_LINE)  victim word being written back
mem_req  out  1  memory request valid
mem_wr  out  1  1 = write, 0 = read
mem_addr  out  32  word-aligned memory address
mem_wdata  out  32  write data
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data
refill_we  out  1  data array write strobe
refill_way  out  log2(WAY_NUM)  way written
refill_index  out  INDEX_WIDTH  set written
refill_word  out  log2(WORDS_PER_LINE)  word written
refill_data  out  32  data written
tag_we  out  1  tag/valid write strobe; sets valid=1, dirty=0, tag=latched miss tag

Behaviour:
- States: IDLE, WB_REQ, RF_REQ, RF_WAIT, DONE.
- Reset: state=IDLE, counters=0, all outputs 0. Reset mid-transfer aborts the transfer immediately; no further mem_req is issued.
- IDLE: when cpu_req & ~hit, latch cpu_addr (tag, index), victim_way mod WAY_NUM, victim_tag and victim_dirty; word counter=0.
  - Go to WB_REQ if victim_valid & victim_dirty, else RF_REQ.
  - stall is combinational: asserted in the miss cycle itself and in every non-IDLE state.
- WB_REQ:
  - Drive mem_req=1, mem_wr=1, mem_addr={victim_tag, index, cnt, 2'b00}, mem_wdata=victim_rdata, wb_word_idx=cnt.
  - Each mem_gnt advances cnt. On mem_gnt at cnt=WORDS_PER_LINE-1, cnt wraps to 0 and the FSM goes to RF_REQ.
  - mem_req stays high and addr/data stay stable until gnt.
- RF_REQ:
  - Drive mem_req=1, mem_wr=0, mem_addr={miss tag, index, cnt, 2'b00}.
  - On mem_gnt go to RF_WAIT; mem_req is low in RF_WAIT.
  - Exactly one read is outstanding at a time.
- RF_WAIT: on mem_rvalid, pulse refill_we for one cycle with refill_word=cnt and refill_data=mem_rdata.
  - If cnt=WORDS_PER_LINE-1: pulse tag_we in the same cycle and go to DONE.
  - Otherwise cnt+1 and back to RF_REQ.
- mem_gnt and mem_rvalid in the same cycle: gnt is honoured only in the REQ states and rvalid only in RF_WAIT. Inputs outside their state are ignored.
- DONE: one cycle with stall=1 so the array re-read hits. Then IDLE with stall=0.
  - cpu_req is not sampled in DONE.
- refill_way, refill_index and tag data hold the latched values for the whole miss; cpu_addr changes during the miss are ignored.
- Latency, clean miss with gnt and rvalid each one cycle after the request: 2*WORDS_PER_LINE + 2 cycles from the miss cycle to stall deassertion.
  - A dirty miss adds WORDS_PER_LINE cycles.

Test Plan:
- Clean miss, addr 0x0000_1040, victim_way=2, gnt/rvalid immediate, rdata=word#: 8 refill_we pulses, refill_way=2, index=0x02, words 0..7, tag_we on the 8th; stall high 18 cycles.
- Dirty miss, victim_tag=0xABCDE, index 0x02: 8 writes to 0xABCDE040..0xABCDE05C with victim_rdata, then the refill reads 0x00001040..0x0000105C.
- Back-pressure: gnt held low 3 cycles on word 3 → mem_req and mem_addr stable for all 3 cycles; no duplicate refill_we.
- victim_way=5 with WAY_NUM=4 → refill_way=1.
- Reset asserted in RF_WAIT after word 4 → next cycle IDLE, stall=0, mem_req=0, no tag_we; the following miss restarts at word 0.
- Hit in IDLE with cpu_req=1: no stall, busy=0, no memory traffic.
